muldiv_hilo: RTL

Sequential multiply/divide unit that owns the architectural HI/LO registers. It replaces the single-cycle combinational mult/multu/div/divu path beside the ALU with a parametrised iterative engine: shift-add multiply and restoring divide. It has a start/busy/done handshake, a flush for exception squash and explicit mthi/mtlo writes. It sits next to `executs32` in the execute stage, and the pipeline control stalls on `busy`.

---
 rtl/muldiv_hilo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// Iterative shift-add multiply / restoring divide unit owning the HI/LO registers.
// Latency: WIDTH+1 cycles from acceptance to done; mthi/mtlo visible the next cycle.
// Backpressure: busy high while in flight; start is ignored while busy, flush aborts.
module muldiv_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;     // mult: {partial, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]     opnd;    // multiplicand or divisor magnitude
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz;

    logic                 signed_op;
    logic                 b_zero;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       r_sh;
    logic [WIDTH+1:0]     diff;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rmd;

    always_comb begin
        signed_op = ~op[0];
        b_zero    = (b == '0);
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

        addend  = acc[0] ? opnd : '0;
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

        r_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = {1'b0, r_sh} - {2'b00, opnd};

        if (is_div) begin
            if (diff[WIDTH+1])
                step = {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            step = {mul_sum, acc[WIDTH-1:1]};
        end

        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (!op[2]) begin
                            is_div <= op[1];
                            // Divide by zero keeps the all-ones quotient unsigned
                            neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && !(op[1] && b_zero);
                            neg_r  <= signed_op && a[WIDTH-1];
                            dz     <= op[1] && b_zero;
                            opnd   <= op[1] ? b_mag : a_mag;
                            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            cnt    <= CNT_W'(WIDTH);
                            busy   <= 1'b1;
                            state  <= RUN;
                        end else if (!op[1]) begin
                            if (op[0])
                                lo <= a;
                            else
                                hi <= a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= step;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            lo <= quo;
                            hi <= rmd;
                        end else begin
                            lo <= prod[WIDTH-1:0];
                            hi <= prod[2*WIDTH-1:WIDTH];
                        end
                        done        <= 1'b1;
                        div_by_zero <= dz;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
